t05_huffman_decoder: RTL and testbench

//  Huffman decoder: inverse of codebook synthesis. Walks the SRAM-resident htree from max_index, one

---
 rtl/t05_hdec_pkg.sv | 31 +++
 rtl/t05_hdec_child_sel.sv | 25 ++
 rtl/t05_huffman_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_t05_huffman_decoder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_hdec_pkg.sv
// Shared types and constants for the Huffman decoder.
// Contents: FSM state enum, htree element field positions, child-field encodings.
package t05_hdec_pkg;

  localparam int unsigned ELEM_W  = 71;
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned CHILD_W = 9;
  localparam int unsigned CHAR_W  = 8;

  localparam int unsigned LEAST1_MSB = 63;
  localparam int unsigned LEAST2_MSB = 54;
  localparam int unsigned SUM_FLAG   = 8;

  // Child encoding that marks an absent branch (sum flag set, payload 0x80).
  localparam logic [CHILD_W-1:0] NULL_NODE = 9'b110000000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_BIT,
    EMIT,
    DONE,
    ERROR
  } hdec_state_e;

  // True when a child field points at another htree element.
  function automatic logic is_sum(input logic [CHILD_W-1:0] child);
    return child[SUM_FLAG];
  endfunction

endpackage

// File: rtl/t05_hdec_child_sel.sv
// Combinational child selection for one tree edge.
// Ports: least1/least2 - child fields of the current element; bit_sel - compressed bit
//        (0 = least1, 1 = least2); is_null_c / is_leaf_c - classification of the chosen
//        child; payload_c - leaf char or next element index in [6:0].
module t05_hdec_child_sel
  import t05_hdec_pkg::*;
(
  input  logic [CHILD_W-1:0] least1,
  input  logic [CHILD_W-1:0] least2,
  input  logic               bit_sel,
  output logic               is_null_c,
  output logic               is_leaf_c,
  output logic [CHAR_W-1:0]  payload_c
);

  logic [CHILD_W-1:0] child;

  always_comb begin
    child     = bit_sel ? least2 : least1;
    is_null_c = (child == NULL_NODE);
    is_leaf_c = !is_sum(child);
    payload_c = child[CHAR_W-1:0];
  end

endmodule

// File: rtl/t05_huffman_decoder.sv
// Huffman decoder: walks the SRAM-resident htree from max_index, one compressed bit per
// edge, and emits one 8-bit char per leaf reached.
// Ports: clk, rst (sync active-high); start/max_index/char_count launch a decode;
//        h_req/h_index/h_valid/h_element fetch htree elements; bit_in/bit_valid/bit_ready
//        take compressed bits; char_out/char_valid/char_ready deliver chars; done/error
//        are status levels.
// Config macro: HDEC_ROOT_CACHE_EN keeps the root element in a register so only the
//        first char of each start fetches the root.
module t05_huffman_decoder
  import t05_hdec_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_DEPTH = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  max_index,
  input  logic [CNT_W-1:0]  char_count,
  output logic              h_req,
  output logic [IDX_W-1:0]  h_index,
  input  logic              h_valid,
  input  logic [ELEM_W-1:0] h_element,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              done,
  output logic              error
);

  localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);

  hdec_state_e        state_q, state_d;
  logic [IDX_W-1:0]   node_q, node_d;
  logic [IDX_W-1:0]   root_q, root_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0]   left_q, left_d;
  logic [CHILD_W-1:0] l1_q, l1_d, l2_q, l2_d;
  logic [CHAR_W-1:0]  char_d;

  logic               h_req_d, bit_ready_d, char_valid_d, done_d, error_d;
  logic [IDX_W-1:0]   h_index_d;
  logic [CHAR_W-1:0]  char_out_d;

  logic               is_null_c, is_leaf_c;
  logic [CHAR_W-1:0]  payload_c;

`ifdef HDEC_ROOT_CACHE_EN
  logic [CHILD_W-1:0] rc_l1_q, rc_l1_d, rc_l2_q, rc_l2_d;
  logic               rc_vld_q, rc_vld_d;
`endif

  // Only the two child fields of an element matter here.
  logic unused_elem_bits;
  assign unused_elem_bits = ^{h_element[ELEM_W-1:LEAST1_MSB+1],
                              h_element[LEAST2_MSB-CHILD_W:0]};

  t05_hdec_child_sel u_child_sel (
    .least1    (l1_q),
    .least2    (l2_q),
    .bit_sel   (bit_in),
    .is_null_c (is_null_c),
    .is_leaf_c (is_leaf_c),
    .payload_c (payload_c)
  );

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d = state_q;
    node_d  = node_q;
    root_d  = root_q;
    depth_d = depth_q;
    left_d  = left_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    char_d  = char_out;
`ifdef HDEC_ROOT_CACHE_EN
    rc_l1_d  = rc_l1_q;
    rc_l2_d  = rc_l2_q;
    rc_vld_d = rc_vld_q;
`endif

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          root_d  = max_index;
          node_d  = max_index;
          left_d  = char_count;
          depth_d = '0;
`ifdef HDEC_ROOT_CACHE_EN
          rc_vld_d = 1'b0;
`endif
          state_d = (char_count == '0) ? DONE : FETCH;
        end
      end

      FETCH: begin
        if (h_valid && h_req) begin
          l1_d    = h_element[LEAST1_MSB -: CHILD_W];
          l2_d    = h_element[LEAST2_MSB -: CHILD_W];
          state_d = WAIT_BIT;
`ifdef HDEC_ROOT_CACHE_EN
          // Depth 0 means this is the root fetch of the current char.
          if (depth_q == '0) begin
            rc_l1_d  = h_element[LEAST1_MSB -: CHILD_W];
            rc_l2_d  = h_element[LEAST2_MSB -: CHILD_W];
            rc_vld_d = 1'b1;
          end
`endif
        end
      end

      WAIT_BIT: begin
        if (bit_valid && bit_ready) begin
          depth_d = DEPTH_W'(depth_q + DEPTH_W'(1));
          if (is_null_c) begin
            state_d = ERROR;
          end else if (is_leaf_c) begin
            char_d  = payload_c;
            state_d = EMIT;
          end else if (depth_d == DEPTH_W'(MAX_DEPTH)) begin
            state_d = ERROR;
          end else begin
            node_d  = payload_c[IDX_W-1:0];
            state_d = FETCH;
          end
        end
      end

      EMIT: begin
        if (char_ready) begin
          depth_d = '0;
          left_d  = (left_q != '0) ? CNT_W'(left_q - CNT_W'(1)) : '0;
          if (left_q <= CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            node_d  = root_q;
            state_d = FETCH;
`ifdef HDEC_ROOT_CACHE_EN
            if (rc_vld_q) begin
              l1_d    = rc_l1_q;
              l2_d    = rc_l2_q;
              state_d = WAIT_BIT;
            end
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase

    h_req_d      = (state_d == FETCH);
    h_index_d    = h_req_d ? node_d : '0;
    bit_ready_d  = (state_d == WAIT_BIT);
    char_valid_d = (state_d == EMIT);
    char_out_d   = char_valid_d ? char_d : '0;
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERROR);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      node_q     <= '0;
      root_q     <= '0;
      depth_q    <= '0;
      left_q     <= '0;
      l1_q       <= '0;
      l2_q       <= '0;
      h_req      <= 1'b0;
      h_index    <= '0;
      bit_ready  <= 1'b0;
      char_out   <= '0;
      char_valid <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef HDEC_ROOT_CACHE_EN
      rc_l1_q    <= '0;
      rc_l2_q    <= '0;
      rc_vld_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      node_q     <= node_d;
      root_q     <= root_d;
      depth_q    <= depth_d;
      left_q     <= left_d;
      l1_q       <= l1_d;
      l2_q       <= l2_d;
      h_req      <= h_req_d;
      h_index    <= h_index_d;
      bit_ready  <= bit_ready_d;
      char_out   <= char_out_d;
      char_valid <= char_valid_d;
      done       <= done_d;
      error      <= error_d;
`ifdef HDEC_ROOT_CACHE_EN
      rc_l1_q    <= rc_l1_d;
      rc_l2_q    <= rc_l2_d;
      rc_vld_q   <= rc_vld_d;
`endif
    end
  end

endmodule

// File: tb/tb_t05_huffman_decoder.sv
// Directed self-checking bench for t05_huffman_decoder with an SRAM responder and bit source.
module tb_t05_huffman_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  max_index;
  logic [15:0] char_count;
  logic        h_req;
  logic [6:0]  h_index;
  logic        h_valid;
  logic [70:0] h_element;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  t05_huffman_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .max_index  (max_index),
    .char_count (char_count),
    .h_req      (h_req),
    .h_index    (h_index),
    .h_valid    (h_valid),
    .h_element  (h_element),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .done       (done),
    .error      (error)
  );

`ifdef HDEC_ROOT_CACHE_EN
  localparam int EXP_FETCHES = 3;   // root once, elem1 twice
`else
  localparam int EXP_FETCHES = 5;   // root per char (3) plus elem1 twice
`endif

  int          checks = 0;
  int          failures = 0;
  logic [70:0] mem [128];
  bit          bitq [$];
  logic [7:0]  chars [$];
  int          bits_taken;
  int          fetches;

  function automatic logic [70:0] mk_elem(input logic [8:0] l1, input logic [8:0] l2);
    logic [70:0] e;
    e        = '0;
    e[63:55] = l1;
    e[54:46] = l2;
    return e;
  endfunction

  // Monitor handshakes on posedge, drive SRAM/bit responses on negedge.
  initial begin
    h_valid   = 1'b0;
    h_element = '0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    forever begin
      @(posedge clk);
      if (bit_valid && bit_ready) begin
        void'(bitq.pop_front());
        bits_taken++;
      end
      if (char_valid && char_ready) chars.push_back(char_out);
      if (h_req && h_valid) fetches++;
      @(negedge clk);
      h_valid   = h_req;
      h_element = mem[h_index];
      bit_valid = (bitq.size() != 0);
      bit_in    = (bitq.size() != 0) ? bitq[0] : 1'b0;
    end
  end

  task automatic load_tree();
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[2] = mk_elem(9'h041, 9'h101);
    mem[1] = mk_elem(9'h042, 9'h043);
  endtask

  task automatic clear_counts();
    bitq.delete();
    chars.delete();
    bits_taken = 0;
    fetches    = 0;
  endtask

  task automatic push_run1_bits();
    bitq.push_back(1'b0);
    bitq.push_back(1'b1);
    bitq.push_back(1'b0);
    bitq.push_back(1'b1);
    bitq.push_back(1'b1);
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic do_start(input logic [6:0] idx, input logic [15:0] cnt);
    start      = 1'b1;
    max_index  = idx;
    char_count = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    for (int i = 0; i < limit && !(done || error); i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({h_req, h_index, bit_ready, char_out, char_valid, done, error} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs: got h_req=%b h_index=%h bit_ready=%b char_out=%h char_valid=%b done=%b error=%b, want all 0",
               h_req, h_index, bit_ready, char_out, char_valid, done, error);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_decode();
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    clear_counts();
    push_run1_bits();
    bitq.push_back(1'b0);
    do_start(7'd2, 16'd3);
    wait_end(300);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL basic_done: got %b want 1", done);
    end
    checks++;
    if (chars.size() != 3) begin
      failures++;
      $display("FAIL basic_char_count: got %0d want 3", chars.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (chars[i] !== exp[i]) begin
          failures++;
          $display("FAIL basic_char%0d: got %h want %h", i, chars[i], exp[i]);
        end
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bits_taken != 5 || bitq.size() != 1) begin
      failures++;
      $display("FAIL basic_bits: got taken=%0d left=%0d want taken=5 left=1", bits_taken, bitq.size());
    end
    checks++;
    if (fetches != EXP_FETCHES) begin
      failures++;
      $display("FAIL basic_fetches: got %0d want %0d", fetches, EXP_FETCHES);
    end
  endtask

  task automatic test_backpressure();
    clear_counts();
    push_run1_bits();
    do_start(7'd2, 16'd3);
    for (int i = 0; i < 200 && chars.size() < 1; i++) @(negedge clk);
    char_ready = 1'b0;
    for (int i = 0; i < 200 && !char_valid; i++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (char_valid !== 1'b1 || char_out !== 8'h42 || bit_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got valid=%b char=%h bit_ready=%b want valid=1 char=42 bit_ready=0",
                 c, char_valid, char_out, bit_ready);
      end
      @(negedge clk);
    end
    char_ready = 1'b1;
    wait_end(300);
    checks++;
    if (chars.size() != 3 || chars[0] !== 8'h41 || chars[1] !== 8'h42 || chars[2] !== 8'h43 || done !== 1'b1) begin
      failures++;
      $display("FAIL bp_stream: got n=%0d done=%b want 41,42,43 done=1", chars.size(), done);
    end
  endtask

  task automatic test_null_error();
    mem[2] = mk_elem(9'h041, 9'h180);
    clear_counts();
    bitq.push_back(1'b1);
    do_start(7'd2, 16'd2);
    wait_end(100);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || chars.size() != 0) begin
      failures++;
      $display("FAIL null_error: got error=%b done=%b chars=%0d want error=1 done=0 chars=0",
               error, done, chars.size());
    end
    load_tree();
    clear_counts();
    bitq.push_back(1'b0);
    do_start(7'd2, 16'd1);
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL error_cleared: got %b want 0", error);
    end
    wait_end(100);
    checks++;
    if (done !== 1'b1 || chars.size() != 1 || chars[0] !== 8'h41) begin
      failures++;
      $display("FAIL relaunch_decode: got done=%b n=%0d want done=1 char 41", done, chars.size());
    end
  endtask

  task automatic test_zero_count();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    bitq.push_back(1'b1);
    do_start(7'd2, 16'd0);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL zero_done: got %b want 1", done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (fetches != 0 || bits_taken != 0) begin
      failures++;
      $display("FAIL zero_activity: got fetches=%0d bits=%0d want 0 0", fetches, bits_taken);
    end
  endtask

  task automatic test_mid_reset();
    clear_counts();
    push_run1_bits();
    do_start(7'd2, 16'd3);
    for (int i = 0; i < 200 && !(chars.size() >= 1 && h_req); i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({h_req, h_index, bit_ready, char_out, char_valid, done, error} !== 21'd0 || chars.size() != 1) begin
      failures++;
      $display("FAIL mid_reset: got h_req=%b bit_ready=%b char_valid=%b done=%b error=%b chars=%0d want all 0, chars=1",
               h_req, bit_ready, char_valid, done, error, chars.size());
    end
    rst = 1'b0;
    clear_counts();
    push_run1_bits();
    do_start(7'd2, 16'd3);
    wait_end(300);
    checks++;
    if (chars.size() != 3 || chars[0] !== 8'h41 || chars[1] !== 8'h42 || chars[2] !== 8'h43 || done !== 1'b1) begin
      failures++;
      $display("FAIL restart_decode: got n=%0d done=%b want 41,42,43 done=1", chars.size(), done);
    end
  endtask

  // Self-looping element never reaches a leaf: error on the 127th edge.
  task automatic test_depth_limit();
    mem[3] = mk_elem(9'h103, 9'h103);
    clear_counts();
    for (int i = 0; i < 130; i++) bitq.push_back(1'b0);
    do_start(7'd3, 16'd1);
    wait_end(2000);
    checks++;
    if (error !== 1'b1 || bits_taken != 127 || chars.size() != 0) begin
      failures++;
      $display("FAIL depth_limit: got error=%b bits=%0d chars=%0d want error=1 bits=127 chars=0",
               error, bits_taken, chars.size());
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    max_index  = '0;
    char_count = '0;
    char_ready = 1'b1;
    bits_taken = 0;
    fetches    = 0;
    load_tree();
    @(negedge clk);
    test_reset();
    test_basic_decode();
    test_backpressure();
    test_null_error();
    test_zero_count();
    test_mid_reset();
    test_depth_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
